cpu_ctrl_fsm: RTL and testbench

Instruction-sequencing controller inside risc_cpu. It runs the fixed 8-state fetch/execute cycle that drives the program-counter, instruction-register, accumulator and bus-control strobes, so every instruction takes exactly 8 sys_clk cycles. It consumes opcode from the instruction register and zero from the accumulator. It produces fetch for u_addr_mux and alu_ena for u_alu, plus rd/wr/halt toward the memory system.

---
 rtl/cpu_ctrl_fsm_pkg.sv | 44 ++++
 rtl/cpu_ctrl_fsm_if.sv | 30 +++
 rtl/cpu_ctrl_fsm_decode.sv | 48 ++++
 rtl/cpu_ctrl_fsm.sv | 84 ++++++++
 tb/tb_cpu_ctrl_fsm.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the risc_cpu instruction sequencer.
package cpu_pkg;

  localparam int unsigned INSTR_CYCLES = 8;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  typedef struct packed {
    logic fetch;
    logic alu_ena;
    logic rd;
    logic wr;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } strobes_t;

  // Opcodes whose execute phase reads an operand into the accumulator.
  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Sequencer-to-datapath signal bundle.
interface cpu_ctrl_fsm_if #(
  parameter int unsigned OPW = 3
);
  logic           ena;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           fetch;
  logic           alu_ena;
  logic           rd;
  logic           wr;
  logic           load_ir;
  logic           inc_pc;
  logic           load_pc;
  logic           load_acc;
  logic           datactl_ena;
  logic           halt;

  modport master (
    input  ena, opcode, zero,
    output fetch, alu_ena, rd, wr, load_ir, inc_pc, load_pc, load_acc,
           datactl_ena, halt
  );

  modport slave (
    output ena, opcode, zero,
    input  fetch, alu_ena, rd, wr, load_ir, inc_pc, load_pc, load_acc,
           datactl_ena, halt
  );
endinterface

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational strobe decode from the state being entered.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_op,
  input  logic       i_skip,
  input  logic       i_frozen,
  output strobes_t   o_strb
);

  // Strobe table indexed by the state the FSM is about to occupy.
  always_comb begin
    o_strb       = '0;
    o_strb.fetch = (i_state == S0) || (i_state == S1) ||
                   (i_state == S2) || (i_state == S3);
    case (i_state)
      S0, S1: begin
        o_strb.rd      = 1'b1;
        o_strb.load_ir = 1'b1;
        o_strb.inc_pc  = 1'b1;
      end
      S3: begin
        // While parked on HLT only the halt level remains; alu_ena pulses once.
        o_strb.alu_ena = !i_frozen;
        o_strb.halt    = (i_op == OP_HLT);
      end
      S4: begin
        o_strb.rd          = is_acc_op(i_op);
        o_strb.datactl_ena = (i_op == OP_STO);
        o_strb.load_pc     = (i_op == OP_JMP);
      end
      S5: begin
        o_strb.rd          = is_acc_op(i_op);
        o_strb.load_acc    = is_acc_op(i_op);
        o_strb.datactl_ena = (i_op == OP_STO);
        o_strb.wr          = (i_op == OP_STO);
        o_strb.inc_pc      = (i_op == OP_SKZ) && i_skip;
      end
      S6: begin
        o_strb.datactl_ena = (i_op == OP_STO);
        o_strb.inc_pc      = (i_op == OP_SKZ) && i_skip;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Eight-state fetch/execute sequencer for risc_cpu with registered strobes.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned OPW         = 3,
  parameter int unsigned HALT_STICKY = 1
) (
  input logic              sys_clk,
  input logic              rst_n,
  cpu_ctrl_fsm_if.master   bus
);

  state_t         r_state;
  logic [OPW-1:0] r_op;
  logic           r_skip;
  strobes_t       r_strb;

  state_t         w_next;
  logic [OPW-1:0] w_op_next;
  logic           w_skip_next;
  logic           w_freeze;
  logic           w_park;
  strobes_t       w_dec;

  // Next state, plus look-ahead opcode/skip so the registered strobes line up
  // with the state they belong to (decode sees the values the regs will hold).
  always_comb begin
    w_freeze = (r_state == S3) && (r_op == OP_HLT) && ((HALT_STICKY != 0) || bus.ena);
    w_park   = !bus.ena && !w_freeze;

    if (w_freeze)      w_next = S3;
    else if (!bus.ena) w_next = S0;
    else               w_next = state_t'(r_state + 3'd1);

    w_op_next = ((r_state == S2) && bus.ena) ? bus.opcode : r_op;

    if ((r_state == S4) && (w_next == S5) && (r_op == OP_SKZ))
      w_skip_next = bus.zero;
    else if ((w_next == S7) || (w_next == S0))
      w_skip_next = 1'b0;
    else
      w_skip_next = r_skip;
  end

  cpu_ctrl_decode u_decode (
    .i_state  (w_next),
    .i_op     (w_op_next),
    .i_skip   (w_skip_next),
    .i_frozen (w_freeze),
    .o_strb   (w_dec)
  );

  // State, opcode latch, skip flag and output strobe registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_op    <= '0;
      r_skip  <= 1'b0;
      r_strb  <= '0;
    end else begin
      r_state <= w_next;
      r_op    <= w_op_next;
      r_skip  <= w_skip_next;
      r_strb  <= w_park ? '0 : w_dec;
    end
  end

  assign bus.fetch       = r_strb.fetch;
  assign bus.alu_ena     = r_strb.alu_ena;
  assign bus.rd          = r_strb.rd;
  assign bus.wr          = r_strb.wr;
  assign bus.load_ir     = r_strb.load_ir;
  assign bus.inc_pc      = r_strb.inc_pc;
  assign bus.load_pc     = r_strb.load_pc;
  assign bus.load_acc    = r_strb.load_acc;
  assign bus.datactl_ena = r_strb.datactl_ena;
  assign bus.halt        = r_strb.halt;

  a_rd_wr_excl : assert property (@(posedge sys_clk) disable iff (!rst_n)
    !(r_strb.rd && r_strb.wr));
  a_pc_excl : assert property (@(posedge sys_clk) disable iff (!rst_n)
    !(r_strb.load_pc && r_strb.inc_pc));

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for the risc_cpu instruction sequencer.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   fails   = 0;
  logic [9:0] q[$];

  cpu_ctrl_fsm_if #(.OPW(3)) bus ();

  cpu_ctrl_fsm #(.OPW(3), .HALT_STICKY(1)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  // Observed order: fetch alu_ena rd wr load_ir inc_pc load_pc load_acc datactl_ena halt
  logic [9:0] w_obs;
  assign w_obs = {bus.fetch, bus.alu_ena, bus.rd, bus.wr, bus.load_ir, bus.inc_pc,
                  bus.load_pc, bus.load_acc, bus.datactl_ena, bus.halt};

  localparam logic [9:0] FROZEN = 10'b10_0000_0001;

  // Reference: expected strobes for instruction cycle c of opcode op.
  function automatic logic [9:0] exp_vec(int c, logic [2:0] op, logic z);
    logic acc;
    logic [9:0] v;
    acc = (op >= 3'd2) && (op <= 3'd5);
    v[9] = (c < 4);
    v[8] = (c == 3);
    v[7] = (c < 2) || (acc && (c == 4 || c == 5));
    v[6] = (op == 3'd6) && (c == 5);
    v[5] = (c < 2);
    v[4] = (c < 2) || ((op == 3'd1) && z && (c == 5 || c == 6));
    v[3] = (op == 3'd7) && (c == 4);
    v[2] = acc && (c == 5);
    v[1] = (op == 3'd6) && (c >= 4) && (c <= 6);
    v[0] = (op == 3'd0) && (c == 3);
    return v;
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_instr(input logic [2:0] op, input logic z, input int first);
    for (int c = first; c < int'(INSTR_CYCLES); c++) q.push_back(exp_vec(c, op, z));
  endtask

  task automatic push_n(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic run(input string tag, input int n);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      if (q.size() == 0) begin
        check($sformatf("%s underflow c%0d", tag, i), w_obs, 10'bx);
      end else begin
        e = q.pop_front();
        check($sformatf("%s c%0d", tag, i), w_obs, e);
      end
    end
  endtask

  initial begin
    bus.ena    = 1'b0;
    bus.opcode = OP_LDA;
    bus.zero   = 1'b0;
    #3;
    check("reset_outputs", w_obs, 10'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Parked with ena low: no strobes.
    push_n(10'b0, 2);
    run("parked", 2);

    // First instruction out of park starts in S0 with no strobes; S1 is seen first.
    bus.ena = 1'b1;
    push_instr(OP_LDA, 1'b0, 1);
    run("lda_first", 7);
    push_instr(OP_LDA, 1'b0, 0);
    run("lda_full", 8);

    // STO, with IR changing after the S2->S3 latch edge.
    bus.opcode = OP_STO;
    push_instr(OP_STO, 1'b0, 0);
    run("sto_a", 4);
    bus.opcode = OP_JMP;
    run("sto_b", 4);

    push_instr(OP_JMP, 1'b0, 0);
    run("jmp", 8);

    // SKZ taken; zero changes after the S4 sampling point and must not matter.
    bus.opcode = OP_SKZ;
    bus.zero   = 1'b1;
    push_instr(OP_SKZ, 1'b1, 0);
    run("skz1_a", 6);
    bus.zero = 1'b0;
    run("skz1_b", 2);
    push_instr(OP_SKZ, 1'b0, 0);
    run("skz0", 8);

    for (int op = 2; op <= 4; op++) begin
      bus.opcode = 3'(op);
      push_instr(3'(op), 1'b0, 0);
      run($sformatf("alu%0d", op), 8);
    end

    // ena drop mid-instruction parks in S0 and restarts from there.
    bus.opcode = OP_LDA;
    push_instr(OP_LDA, 1'b0, 0);
    run("ena_a", 3);
    q.delete();
    bus.ena = 1'b0;
    push_n(10'b0, 2);
    run("ena_park", 2);
    bus.ena = 1'b1;
    push_instr(OP_LDA, 1'b0, 1);
    run("ena_resume", 7);

    // Asynchronous reset during S5 of STO.
    bus.opcode = OP_STO;
    push_instr(OP_STO, 1'b0, 0);
    run("sto_rst", 6);
    q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sto", w_obs, 10'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    push_instr(OP_STO, 1'b0, 1);
    run("sto_restart", 7);
    push_instr(OP_STO, 1'b0, 0);
    run("sto_again", 8);

    // HLT freezes in S3; sticky even with ena low.
    bus.opcode = OP_HLT;
    push_instr(OP_HLT, 1'b0, 0);
    q.pop_back(); q.pop_back(); q.pop_back(); q.pop_back();
    push_n(FROZEN, 12);
    run("hlt", 16);
    bus.ena = 1'b0;
    push_n(FROZEN, 10);
    run("hlt_sticky", 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hlt", w_obs, 10'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    push_n(10'b0, 2);
    run("post_hlt_park", 2);

    if (q.size() != 0) check("queue_drained", 10'(q.size()), 10'b0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
